uart_stream_tx: RTL and testbench
=================================

UART_STREAM_TX -- requirements
Module: uart_stream_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter DIV_W, default 16, meaning clock-divider width.
REQ-003 SHALL have port axis_clk  input  1  the single clock.
REQ-004 SHALL have port axis_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port s_tdata  input  8  byte to send.
REQ-006 SHALL have port s_tvalid  input  1  byte valid.
REQ-007 SHALL have port s_tready  output  1  byte accepted when high with s_tvalid.
REQ-008 SHALL have port clk_div  input  DIV_W  bit period minus one, in clocks.
REQ-009 SHALL have port tx_en  input  1  permits starting new frames.
REQ-010 SHALL have port txd  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  frame in progress or FIFO non-empty.
REQ-012 SHALL have port fifo_level  output  $clog2(DEPTH)+1  entries held.

Function
REQ-013 SHALL use a frame format of 8N1: start bit 0, data LSB first, one stop bit 1.
REQ-014 SHALL hold each bit on txd for clk_div+1 cycles; clk_div=0 gives one cycle per bit; frame = 10*(clk_div+1) cycles.
REQ-015 SHALL sample clk_div once at frame start; changes mid-frame take effect at the next frame.
REQ-016 SHALL drive s_tready = (fifo_level != DEPTH), combinationally from registered state only.
REQ-017 SHALL write s_tdata to the FIFO on every edge where s_tvalid && s_tready.
REQ-018 SHALL use an FSM with states IDLE, START, DATA, STOP.
REQ-019 SHALL transition IDLE->START when FIFO non-empty and tx_en=1; the head byte is popped into the shift register on that same edge and txd goes low after it.
REQ-020 SHALL give one-cycle latency: a byte handshaken at edge k into an empty FIFO while IDLE with tx_en=1 drives txd low after edge k+1.
REQ-021 SHALL transition START->DATA after one bit period, DATA->STOP after 8 bit periods (3-bit index wraps 7->0), and STOP->START directly (no idle cycle) if FIFO non-empty and tx_en=1, else STOP->IDLE.
REQ-022 SHALL leave fifo_level unchanged when a push and a pop occur on the same edge.
REQ-023 SHALL NOT accept a push while full, even on the pop edge (tready is low for that cycle).
REQ-024 SHALL complete the current frame when tx_en drops mid-frame, then remain IDLE with FIFO contents retained.
REQ-025 SHALL keep txd high in IDLE and STOP.
REQ-026 SHALL drive busy = (state != IDLE) || (fifo_level != 0).

Reset
REQ-027 SHALL, on axis_rst_n low (asynchronous, including mid-frame), force state IDLE, txd=1, busy=0, fifo_level=0, s_tready=0 while reset is asserted, pointers=0, and the shift register and bit counter to 0.
REQ-028 SHALL discard all FIFO contents on reset; the partial frame is abandoned with txd high.
REQ-029 SHALL raise s_tready on the first edge after reset release.

Structure
REQ-030 SHALL place the FSM state enum and the frame constants (DATA_BITS=8, BITS_PER_FRAME=10) in shared package uart_pkg.
REQ-031 SHALL implement the FIFO as one sub-module, sync_fifo (parameters DEPTH and WIDTH=8); the baud counter and FSM reside in the top module.

Verification
REQ-032 SHALL cover: clk_div=3, send 0x55 -> txd = 0,1,0,1,0,1,0,1,0,1, each level 4 cycles, 40 cycles total, then txd high and busy=0.
REQ-033 SHALL cover: tx_en=0, push 0xA5,0x5A,0xAB,0x40,0x51 on consecutive cycles -> first four accepted, s_tready low, fifo_level=4, txd stays high; then raise tx_en -> five frames total, back-to-back, with no idle cycle between stop and start.
REQ-034 SHALL cover: clk_div=0, single byte 0x80 handshaken at edge k -> txd low after edge k+1, data 0000000 1, stop, frame length exactly 10 cycles.
REQ-035 SHALL cover: reset asserted during bit 4 of 0xFF with 2 bytes queued -> txd=1 immediately, fifo_level=0, busy=0; after release, no frame is sent.
REQ-036 SHALL cover: tx_en dropped during the DATA state of 0x3C with 1 byte queued -> 0x3C frame completes, the queued byte is held, fifo_level=1, busy=1.
REQ-037 SHALL check all frames with a serial-receive monitor at the programmed bit period, which compares the decoded bytes against pushed bytes in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART stream transmitter: FSM state encoding,
// 8N1 frame constants and the line-level decode used by the serializer.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS      = 8;
    localparam int BITS_PER_FRAME = 10;

    // Serial line level for a given state; the line idles high and the stop bit is high.
    function automatic logic txd_level(input tx_state_e st, input logic data_bit);
        case (st)
            START:   return 1'b0;
            DATA:    return data_bit;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_stream_tx_if.sv
// Valid/ready byte stream bundle; the source drives master, the sink uses slave.
interface uart_stream_tx_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a valid/ready write port and a pop strobe on the read side.
// Write-ready is held low until the first clock edge after reset release.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_stream_tx_if.slave        wr,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             accept_q;
    logic             push;
    logic             pop;

    // Ready depends on registered state only, so a full FIFO refuses a push even on a pop edge.
    assign wr.tready = accept_q && (count_q != FULL_LEVEL);
    assign push      = wr.tvalid && wr.tready;
    assign pop       = rd_en && (count_q != '0);
    assign rd_data   = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign level     = count_q;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            accept_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            accept_q <= 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; clearing pointers and count discards the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr.tdata;
        end
    end

endmodule

// File: rtl/uart_stream_tx.sv
// Byte-stream to 8N1 UART transmitter: a small FIFO feeds a serializer whose bit
// period (clk_div+1 clocks) is captured at the start of every frame.
module uart_stream_tx
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic [7:0]             s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [DIV_W-1:0]       clk_div,
    input  logic                   tx_en,
    output logic                   txd,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [2:0]             bit_idx_q, bit_idx_d;

    logic                   pop;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_data;
    logic                   start_ok;
    logic                   bit_end;

    uart_stream_tx_if #(.WIDTH(DATA_BITS)) wr_if ();

    assign wr_if.tdata  = s_tdata;
    assign wr_if.tvalid = s_tvalid;
    assign s_tready     = wr_if.tready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (axis_clk),
        .rst_n   (axis_rst_n),
        .wr      (wr_if.slave),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign start_ok = tx_en && !fifo_empty;
    assign bit_end  = (cnt_q == div_q);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q + DIV_W'(1);
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_ok) begin
                    state_d = START;
                    pop     = 1'b1;
                    shift_d = fifo_data;
                    div_d   = clk_div;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when more data is waiting.
                    if (start_ok) begin
                        state_d = START;
                        pop     = 1'b1;
                        shift_d = fifo_data;
                        div_d   = clk_div;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign txd  = txd_level(state_q, shift_q[0]);
    assign busy = (state_q != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_stream_tx.sv
// Directed bench for uart_stream_tx: table of single-frame vectors plus hand-written
// sequences for fill/back-to-back, mid-frame reset and tx_en drop, with a serial monitor.
module tb_uart_stream_tx;
    import uart_pkg::*;

    localparam int DEPTH = 4;
    localparam int DIV_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             axis_clk = 1'b0;
    logic             axis_rst_n;
    logic [DIV_W-1:0] clk_div;
    logic             tx_en;
    logic             txd;
    logic             busy;
    logic [LW-1:0]    fifo_level;

    uart_stream_tx_if #(.WIDTH(8)) axis ();

    always #5 axis_clk = ~axis_clk;

    uart_stream_tx #(
        .DEPTH (DEPTH),
        .DIV_W (DIV_W)
    ) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .s_tdata    (axis.tdata),
        .s_tvalid   (axis.tvalid),
        .s_tready   (axis.tready),
        .clk_div    (clk_div),
        .tx_en      (tx_en),
        .txd        (txd),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge axis_clk);
        #1;
    endtask

    // Serial receive monitor: decodes frames at the programmed bit period and
    // compares them in order against the bytes the bench has queued.
    logic [7:0] exp_q [$];
    int         mon_p = 1;
    bit         mon_abort = 1'b0;
    int         frames_seen = 0;

    always begin : monitor
        logic [7:0] rx_byte;
        logic       start_bit;
        logic       stop_bit;
        int         p;
        @(negedge axis_clk);
        if (axis_rst_n === 1'b1 && txd === 1'b0) begin
            mon_abort = 1'b0;
            p = mon_p;
            repeat (p / 2) @(negedge axis_clk);
            start_bit = txd;
            for (int i = 0; i < 8; i++) begin
                repeat (p) @(negedge axis_clk);
                rx_byte[i] = txd;
            end
            repeat (p) @(negedge axis_clk);
            stop_bit = txd;
            if (!mon_abort) begin
                frames_seen++;
                check("mon start bit", start_bit, 1'b0);
                check("mon stop bit", stop_bit, 1'b1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL mon unexpected frame: got 0x%02h, no byte pending", rx_byte);
                end else begin
                    check("mon byte", rx_byte, exp_q.pop_front());
                end
            end
        end
    end

    typedef struct {
        logic [7:0]       data;
        logic [DIV_W-1:0] div;
        logic [9:0]       frame;   // bit i = txd level during bit slot i
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] fill_bytes [5];
    int         p;
    logic [9:0] got;
    bit         flag;
    bit         flag2;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h55, 16'd3, 10'h2AA};
        vecs[1] = '{8'h80, 16'd0, 10'h300};
        vecs[2] = '{8'hA5, 16'd1, 10'h34A};
        vecs[3] = '{8'h00, 16'd2, 10'h200};
        vecs[4] = '{8'hFF, 16'd4, 10'h3FE};
        fill_bytes[0] = 8'hA5;
        fill_bytes[1] = 8'h5A;
        fill_bytes[2] = 8'hAB;
        fill_bytes[3] = 8'h40;
        fill_bytes[4] = 8'h51;

        axis_rst_n  = 1'b0;
        tx_en       = 1'b0;
        clk_div     = '0;
        axis.tdata  = '0;
        axis.tvalid = 1'b0;

        // Reset state
        #23;
        check("reset txd", txd, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset fifo_level", fifo_level, 0);
        check("reset tready", axis.tready, 1'b0);
        @(negedge axis_clk);
        #2 axis_rst_n = 1'b1;
        check("tready before first edge", axis.tready, 1'b0);
        step();
        check("tready after first edge", axis.tready, 1'b1);

        // Single-frame vectors
        tx_en = 1'b1;
        for (int v = 0; v < 5; v++) begin
            clk_div = vecs[v].div;
            mon_p   = int'(vecs[v].div) + 1;
            p       = mon_p;
            axis.tdata  = vecs[v].data;
            axis.tvalid = 1'b1;
            check("vec tready", axis.tready, 1'b1);
            exp_q.push_back(vecs[v].data);
            step();
            axis.tvalid = 1'b0;
            check("vec level after push", fifo_level, 1);
            check("vec txd high at handshake", txd, 1'b1);
            step();
            check("vec level after pop", fifo_level, 0);
            got  = '0;
            flag = 1'b1;
            for (int c = 0; c < BITS_PER_FRAME * p; c++) begin
                if (c % p == 0) got[c / p] = txd;
                else if (txd !== got[c / p]) flag = 1'b0;
                step();
            end
            check("vec frame bits", got, vecs[v].frame);
            check("vec bits stable", flag, 1'b1);
            check("vec txd idle after frame", txd, 1'b1);
            check("vec busy after frame", busy, 1'b0);
            step(2);
        end

        // Fill with tx_en low, then release for back-to-back frames
        tx_en   = 1'b0;
        clk_div = 16'd1;
        mon_p   = 2;
        p       = 2;
        for (int i = 0; i < 5; i++) begin
            axis.tdata  = fill_bytes[i];
            axis.tvalid = 1'b1;
            check("fill level", fifo_level, (i < 4) ? i : 4);
            check("fill tready", axis.tready, (i < 4) ? 1 : 0);
            if (i < 4) exp_q.push_back(fill_bytes[i]);
            step();
        end
        check("full level", fifo_level, 4);
        check("full tready", axis.tready, 1'b0);
        check("full busy", busy, 1'b1);
        flag = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (txd !== 1'b1) flag = 1'b0;
            step();
        end
        check("full txd held high", flag, 1'b1);
        check("full level held", fifo_level, 4);

        tx_en = 1'b1;
        exp_q.push_back(8'h51);
        step();
        check("b2b first start", txd, 1'b0);
        check("b2b level after pop", fifo_level, 3);
        check("b2b tready after pop", axis.tready, 1'b1);
        step();
        axis.tvalid = 1'b0;
        check("b2b level after late push", fifo_level, 4);
        flag  = 1'b1;
        flag2 = 1'b1;
        for (int c = 1; c < 5 * BITS_PER_FRAME * p; c++) begin
            if (busy !== 1'b1) flag = 1'b0;
            if (c % (BITS_PER_FRAME * p) == 0 && txd !== 1'b0) flag2 = 1'b0;
            if (c % (BITS_PER_FRAME * p) == BITS_PER_FRAME * p - 1 && txd !== 1'b1) flag2 = 1'b0;
            step();
        end
        check("b2b busy continuous", flag, 1'b1);
        check("b2b frame boundaries", flag2, 1'b1);
        check("b2b busy after five frames", busy, 1'b0);
        check("b2b txd idle after five frames", txd, 1'b1);
        check("b2b level drained", fifo_level, 0);
        step(2);

        // Reset during bit 4 of 0xFF with two bytes queued
        axis.tdata  = 8'hFF;
        axis.tvalid = 1'b1;
        step();
        axis.tdata = 8'h11;
        step();
        axis.tdata = 8'h22;
        step();
        axis.tvalid = 1'b0;
        check("rst queued level", fifo_level, 2);
        step(9);
        check("rst bit4 level", txd, 1'b1);
        check("rst busy mid-frame", busy, 1'b1);
        #2;
        axis_rst_n = 1'b0;
        mon_abort  = 1'b1;
        #1;
        check("rst txd immediate", txd, 1'b1);
        check("rst level immediate", fifo_level, 0);
        check("rst busy immediate", busy, 1'b0);
        check("rst tready immediate", axis.tready, 1'b0);
        step(2);
        check("rst tready held", axis.tready, 1'b0);
        #3 axis_rst_n = 1'b1;
        step();
        check("rst tready after release", axis.tready, 1'b1);
        flag = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (txd !== 1'b1 || busy !== 1'b0) flag = 1'b0;
            step();
        end
        check("rst no frame after release", flag, 1'b1);

        // tx_en dropped during the DATA state of 0x3C with one byte queued
        clk_div = 16'd2;
        mon_p   = 3;
        axis.tdata  = 8'h3C;
        axis.tvalid = 1'b1;
        exp_q.push_back(8'h3C);
        step();
        axis.tdata = 8'h99;
        step();
        axis.tvalid = 1'b0;
        check("drop start bit", txd, 1'b0);
        check("drop queued level", fifo_level, 1);
        step(10);
        tx_en = 1'b0;
        step(20);
        check("drop txd idle", txd, 1'b1);
        check("drop level held", fifo_level, 1);
        check("drop busy held", busy, 1'b1);
        check("drop tready", axis.tready, 1'b1);
        flag = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (txd !== 1'b1) flag = 1'b0;
            step();
        end
        check("drop txd stays high", flag, 1'b1);
        check("drop level still held", fifo_level, 1);
        tx_en = 1'b1;
        exp_q.push_back(8'h99);
        step(35);
        check("resume busy", busy, 1'b0);
        check("resume level", fifo_level, 0);

        step(5);
        check("all frames received", exp_q.size(), 0);
        check("frame count", frames_seen, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
